// File: rtl/coef_load_ctrl.sv
// Coefficient load / calc sequencer for the four sub-filter RAMs behind module_selector.
// Every output is registered. The next value of each register is computed in one combinational block.
module coef_load_ctrl #(
    parameter int NUM_MOD      = 4,
    parameter int TAPS_PER_MOD = 10,
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 4,
    parameter int SEL_W        = 2
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iCoefUpdate,
    input  logic              iCoefValid,
    input  logic [DATA_W-1:0] iCoefData,
    output logic              oCoefReady,
    input  logic              iSampleValid,
    output logic [SEL_W-1:0]  oModuleSel,
    output logic              oCsnRam,
    output logic              oWrnRam,
    output logic [ADDR_W-1:0] oAddrRam,
    output logic [DATA_W-1:0] oWtDtRam,
    output logic              oEnMul,
    output logic              oEnAddAcc,
    output logic              oLoadDone,
    output logic              oCalcDone,
    output logic              oBusy
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_CALC = 2'd2} state_t;

    state_t            r_state, w_nxt_state;
    logic [SEL_W-1:0]  r_sel, w_nxt_sel, w_inc_sel;
    logic [ADDR_W-1:0] r_addr, w_nxt_addr, w_inc_addr;
    logic              r_loaded, w_nxt_loaded;
    logic              r_coef_ready, w_nxt_coef_ready;
    logic [SEL_W-1:0]  r_mod_sel, w_nxt_mod_sel;
    logic              r_csn, w_nxt_csn;
    logic              r_wrn, w_nxt_wrn;
    logic [ADDR_W-1:0] r_addr_ram, w_nxt_addr_ram;
    logic [DATA_W-1:0] r_wt_dt, w_nxt_wt_dt;
    logic              r_en_mul, w_nxt_en_mul;
    logic              r_en_acc, w_nxt_en_acc;
    logic              r_load_done, w_nxt_load_done;
    logic              r_calc_done, w_nxt_calc_done;
    logic              r_busy, w_nxt_busy;
    logic              w_last, w_accept;

    assign w_last     = (r_sel == SEL_W'(NUM_MOD - 1)) && (r_addr == ADDR_W'(TAPS_PER_MOD - 1));
    assign w_accept   = iCoefValid && r_coef_ready;
    assign w_inc_addr = (r_addr == ADDR_W'(TAPS_PER_MOD - 1)) ? '0 : r_addr + ADDR_W'(1);
    assign w_inc_sel  = (r_addr == ADDR_W'(TAPS_PER_MOD - 1)) ? r_sel + SEL_W'(1) : r_sel;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state      <= S_IDLE;
            r_sel        <= '0;
            r_addr       <= '0;
            r_loaded     <= 1'b0;
            r_coef_ready <= 1'b0;
            r_mod_sel    <= '0;
            r_csn        <= 1'b1;
            r_wrn        <= 1'b1;
            r_addr_ram   <= '0;
            r_wt_dt      <= '0;
            r_en_mul     <= 1'b0;
            r_en_acc     <= 1'b0;
            r_load_done  <= 1'b0;
            r_calc_done  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_sel        <= w_nxt_sel;
            r_addr       <= w_nxt_addr;
            r_loaded     <= w_nxt_loaded;
            r_coef_ready <= w_nxt_coef_ready;
            r_mod_sel    <= w_nxt_mod_sel;
            r_csn        <= w_nxt_csn;
            r_wrn        <= w_nxt_wrn;
            r_addr_ram   <= w_nxt_addr_ram;
            r_wt_dt      <= w_nxt_wt_dt;
            r_en_mul     <= w_nxt_en_mul;
            r_en_acc     <= w_nxt_en_acc;
            r_load_done  <= w_nxt_load_done;
            r_calc_done  <= w_nxt_calc_done;
            r_busy       <= w_nxt_busy;
        end
    end

    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_sel        = r_sel;
        w_nxt_addr       = r_addr;
        w_nxt_loaded     = r_loaded;
        w_nxt_coef_ready = 1'b0;
        w_nxt_mod_sel    = '0;
        w_nxt_csn        = 1'b1;
        w_nxt_wrn        = 1'b1;
        w_nxt_addr_ram   = '0;
        w_nxt_wt_dt      = '0;
        w_nxt_en_mul     = 1'b0;
        w_nxt_en_acc     = 1'b0;
        w_nxt_load_done  = 1'b0;
        w_nxt_calc_done  = 1'b0;
        w_nxt_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_nxt_sel  = '0;
                w_nxt_addr = '0;
                if (iCoefUpdate) begin
                    w_nxt_state      = S_LOAD;
                    w_nxt_loaded     = 1'b0;
                    w_nxt_coef_ready = 1'b1;
                    w_nxt_busy       = 1'b1;
                end else if (iSampleValid && r_loaded) begin
                    // First read beat goes out with the transition; counters track the beat on the bus.
                    w_nxt_state  = S_CALC;
                    w_nxt_csn    = 1'b0;
                    w_nxt_en_mul = 1'b1;
                    w_nxt_en_acc = 1'b1;
                    w_nxt_busy   = 1'b1;
                end
            end
            S_LOAD: begin
                w_nxt_coef_ready = 1'b1;
                w_nxt_busy       = 1'b1;
                w_nxt_mod_sel    = r_mod_sel;
                w_nxt_addr_ram   = r_addr_ram;
                w_nxt_wt_dt      = r_wt_dt;
                if (w_accept) begin
                    w_nxt_csn      = 1'b0;
                    w_nxt_wrn      = 1'b0;
                    w_nxt_mod_sel  = r_sel;
                    w_nxt_addr_ram = r_addr;
                    w_nxt_wt_dt    = iCoefData;
                    w_nxt_sel      = w_inc_sel;
                    w_nxt_addr     = w_inc_addr;
                    if (w_last) begin
                        // Ready drops on the 40th accept edge so a 41st word can never be taken.
                        w_nxt_state      = S_IDLE;
                        w_nxt_sel        = '0;
                        w_nxt_addr       = '0;
                        w_nxt_loaded     = 1'b1;
                        w_nxt_coef_ready = 1'b0;
                        w_nxt_busy       = 1'b0;
                        w_nxt_load_done  = 1'b1;
                    end
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_nxt_state     = S_IDLE;
                    w_nxt_sel       = '0;
                    w_nxt_addr      = '0;
                    w_nxt_calc_done = 1'b1;
                end else begin
                    w_nxt_sel      = w_inc_sel;
                    w_nxt_addr     = w_inc_addr;
                    w_nxt_csn      = 1'b0;
                    w_nxt_en_mul   = 1'b1;
                    w_nxt_en_acc   = 1'b1;
                    w_nxt_busy     = 1'b1;
                    w_nxt_mod_sel  = w_inc_sel;
                    w_nxt_addr_ram = w_inc_addr;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_sel   = '0;
                w_nxt_addr  = '0;
            end
        endcase
    end

    assign oCoefReady = r_coef_ready;
    assign oModuleSel = r_mod_sel;
    assign oCsnRam    = r_csn;
    assign oWrnRam    = r_wrn;
    assign oAddrRam   = r_addr_ram;
    assign oWtDtRam   = r_wt_dt;
    assign oEnMul     = r_en_mul;
    assign oEnAddAcc  = r_en_acc;
    assign oLoadDone  = r_load_done;
    assign oCalcDone  = r_calc_done;
    assign oBusy      = r_busy;

endmodule

// File: tb/tb_coef_load_ctrl.sv
// Bench for coef_load_ctrl: directed phases then random traffic, checked each cycle against a
// behavioural model that tracks a flat accept count / sweep step and derives (sel, addr) by div/mod.
module tb_coef_load_ctrl;

    logic        iClk = 1'b0;
    logic        iRst, iCoefUpdate, iCoefValid, iSampleValid;
    logic [15:0] iCoefData;
    logic        oCoefReady, oCsnRam, oWrnRam, oEnMul, oEnAddAcc, oLoadDone, oCalcDone, oBusy;
    logic [1:0]  oModuleSel;
    logic [3:0]  oAddrRam;
    logic [15:0] oWtDtRam;

    coef_load_ctrl dut (
        .iClk(iClk), .iRst(iRst), .iCoefUpdate(iCoefUpdate), .iCoefValid(iCoefValid),
        .iCoefData(iCoefData), .oCoefReady(oCoefReady), .iSampleValid(iSampleValid),
        .oModuleSel(oModuleSel), .oCsnRam(oCsnRam), .oWrnRam(oWrnRam), .oAddrRam(oAddrRam),
        .oWtDtRam(oWtDtRam), .oEnMul(oEnMul), .oEnAddAcc(oEnAddAcc), .oLoadDone(oLoadDone),
        .oCalcDone(oCalcDone), .oBusy(oBusy)
    );

    always #5 iClk = ~iClk;

    // Behavioural model: mode 0 idle, 1 load, 2 calc
    int          m_mode, m_cnt, m_step;
    logic        m_loaded;
    logic        e_ready, e_csn, e_wrn, e_mul, e_acc, e_ldone, e_cdone, e_busy;
    logic [1:0]  e_sel;
    logic [3:0]  e_addr;
    logic [15:0] e_wd;

    task automatic idle_def();
        e_ready = 0; e_csn = 1; e_wrn = 1; e_mul = 0; e_acc = 0;
        e_ldone = 0; e_cdone = 0; e_busy = 0; e_sel = 0; e_addr = 0; e_wd = 0;
    endtask

    task automatic read_beat(input int i);
        idle_def();
        e_csn = 0; e_mul = 1; e_acc = 1; e_busy = 1;
        e_sel = 2'(i / 10); e_addr = 4'(i % 10);
    endtask

    always @(posedge iClk) begin
        if (iRst) begin
            m_mode = 0; m_loaded = 0; m_cnt = 0; m_step = 0;
            idle_def();
        end else begin
            case (m_mode)
                0: begin
                    idle_def();
                    if (iCoefUpdate) begin
                        m_mode = 1; m_loaded = 0; m_cnt = 0;
                        e_ready = 1; e_busy = 1;
                    end else if (iSampleValid && m_loaded) begin
                        m_mode = 2; m_step = 0;
                        read_beat(0);
                    end
                end
                1: begin
                    e_csn = 1; e_wrn = 1; e_ready = 1; e_busy = 1;
                    e_mul = 0; e_acc = 0; e_ldone = 0; e_cdone = 0;
                    if (iCoefValid) begin
                        e_csn = 0; e_wrn = 0;
                        e_sel = 2'(m_cnt / 10); e_addr = 4'(m_cnt % 10); e_wd = iCoefData;
                        m_cnt++;
                        if (m_cnt == 40) begin
                            m_mode = 0; m_loaded = 1;
                            e_ready = 0; e_busy = 0; e_ldone = 1;
                        end
                    end
                end
                default: begin
                    m_step++;
                    if (m_step == 40) begin
                        m_mode = 0;
                        idle_def();
                        e_cdone = 1;
                    end else begin
                        read_beat(m_step);
                    end
                end
            endcase
        end
    end

    int n_vec = 0, n_err = 0;
    int n_wr = 0, n_rd = 0, n_busy = 0, n_cdone = 0, n_ldone = 0;
    logic [15:0] wr_q[$];
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Every cycle passes through here: full output compare against the model plus activity counters.
    task automatic tick();
        @(negedge iClk);
        if (chk_en) begin
            chk("ready",  32'(oCoefReady), 32'(e_ready));
            chk("csn",    32'(oCsnRam),    32'(e_csn));
            chk("wrn",    32'(oWrnRam),    32'(e_wrn));
            chk("sel",    32'(oModuleSel), 32'(e_sel));
            chk("addr",   32'(oAddrRam),   32'(e_addr));
            chk("wdata",  32'(oWtDtRam),   32'(e_wd));
            chk("enmul",  32'(oEnMul),     32'(e_mul));
            chk("enacc",  32'(oEnAddAcc),  32'(e_acc));
            chk("ldone",  32'(oLoadDone),  32'(e_ldone));
            chk("cdone",  32'(oCalcDone),  32'(e_cdone));
            chk("busy",   32'(oBusy),      32'(e_busy));
            if (!oCsnRam && !oWrnRam) begin n_wr++; wr_q.push_back(oWtDtRam); end
            if (!oCsnRam && oWrnRam) n_rd++;
            if (oBusy) n_busy++;
            if (oCalcDone) n_cdone++;
            if (oLoadDone) n_ldone++;
        end
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input logic [15:0] base, input bit toggle);
        int  k;
        int  guard;
        logic acc;
        k = 0; guard = 0;
        iCoefUpdate = 1; tick(); iCoefUpdate = 0;
        while (k < 40 && guard < 400) begin
            iCoefValid = toggle ? guard[0] : 1'b1;
            iCoefData  = base + 16'(k);
            acc = iCoefValid && e_ready;
            tick();
            if (acc) k++;
            guard++;
        end
        if (k < 40) chk("load_timeout", 32'(k), 32'd40);
        iCoefValid = 0;
        ticks(2);
    endtask

    int s_wr, s_rd, s_busy, s_cd, s_ld, guard;

    initial begin
        iRst = 1; iCoefUpdate = 0; iCoefValid = 0; iCoefData = 0; iSampleValid = 0;
        tick(); chk_en = 1; tick();
        chk("rst_csn",  32'(oCsnRam), 32'd1);
        chk("rst_busy", 32'(oBusy),   32'd0);
        iRst = 0; tick();

        // 1: reset during an active load, then a sample must be ignored
        iCoefUpdate = 1; tick(); iCoefUpdate = 0;
        iCoefValid = 1;
        for (int i = 0; i < 5; i++) begin iCoefData = 16'h0100 + 16'(i); tick(); end
        iRst = 1; ticks(2); iRst = 0; iCoefValid = 0;
        iSampleValid = 1; tick(); iSampleValid = 0; ticks(3);
        chk("t1_busy",  32'(oBusy),   32'd0);
        chk("t1_csn",   32'(oCsnRam), 32'd1);

        // 2: back-to-back load
        s_wr = n_wr; s_ld = n_ld_snapshot();
        do_load(16'hFACE, 1'b0);
        chk("t2_nwr",   32'(n_wr - s_wr), 32'd40);
        chk("t2_first", 32'(wr_q[s_wr]),      32'hFACE);
        chk("t2_last",  32'(wr_q[s_wr + 39]), 32'hFACE + 32'd39);
        chk("t2_ldone", 32'(n_ldone - s_ld),  32'd1);

        // 3: stalled load
        s_wr = n_wr;
        do_load(16'h1000, 1'b1);
        chk("t3_nwr",   32'(n_wr - s_wr), 32'd40);
        chk("t3_w17",   32'(wr_q[s_wr + 17]), 32'h1011);

        // 4: one sweep
        s_rd = n_rd; s_busy = n_busy; s_cd = n_cdone;
        iSampleValid = 1; tick(); iSampleValid = 0; ticks(45);
        chk("t4_reads", 32'(n_rd - s_rd),      32'd40);
        chk("t4_busy",  32'(n_busy - s_busy),  32'd40);
        chk("t4_cdone", 32'(n_cdone - s_cd),   32'd1);

        // 5: sample mid-sweep dropped, then restart right after done
        s_rd = n_rd; s_cd = n_cdone;
        iSampleValid = 1; tick(); iSampleValid = 0;
        ticks(19);
        iSampleValid = 1; tick(); iSampleValid = 0;
        guard = 0;
        while (!oCalcDone && guard < 100) begin tick(); guard++; end
        if (guard >= 100) chk("t5_timeout", 32'(guard), 32'd0);
        tick();
        iSampleValid = 1; tick(); iSampleValid = 0; ticks(45);
        chk("t5_reads", 32'(n_rd - s_rd),    32'd80);
        chk("t5_cdone", 32'(n_cdone - s_cd), 32'd2);

        // 6: update beats sample in IDLE
        s_rd = n_rd;
        iCoefUpdate = 1; iSampleValid = 1; tick(); iCoefUpdate = 0; iSampleValid = 0;
        chk("t6_ready", 32'(oCoefReady), 32'd1);
        ticks(3);
        chk("t6_noread", 32'(n_rd - s_rd), 32'd0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            iCoefUpdate  = ($urandom % 70) == 0;
            iSampleValid = ($urandom % 6) == 0;
            iCoefValid   = ($urandom % 3) != 0;
            iCoefData    = 16'($urandom);
            iRst         = ($urandom % 700) == 0;
            tick();
        end
        iRst = 0; iCoefUpdate = 0; iSampleValid = 0; iCoefValid = 0;
        ticks(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    function automatic int n_ld_snapshot();
        return n_ldone;
    endfunction

endmodule
